// File: rtl/bang_bank.sv
// Multi-channel damped two-pole "crash" resonator bank with one shared multiplier pair.
// Channels are computed one per cycle after each sample strobe, then summed and saturated.
module bang_bank #(
  parameter int CHANNELS  = 2,
  parameter int CRSH_W    = 4,
  parameter int OUT_W     = 16,
  parameter int A1_Q14    = 32745,
  parameter int A2_Q14    = 16364,
  parameter int KICK_GAIN = 16,
  parameter int FLOOR     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clk_en_48KHz,
  input  logic [CHANNELS*CRSH_W-1:0] crsh,
  output logic signed [OUT_W-1:0]    out,
  output logic [CHANNELS-1:0]        active,
  output logic                       sample_valid
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = 24 + $clog2(CHANNELS) + 1;
  localparam int PW = 48;

  localparam logic signed [PW-1:0] A1_S  = PW'(A1_Q14);
  localparam logic signed [PW-1:0] A2_S  = PW'(A2_Q14);
  localparam logic signed [PW-1:0] K_S   = PW'(KICK_GAIN);
  localparam logic signed [PW-1:0] FL_S  = PW'(FLOOR);
  localparam logic signed [PW-1:0] Y_MAX = PW'(8388607);
  localparam logic signed [PW-1:0] Y_MIN = -PW'(8388608);
  localparam logic signed [SW-1:0] O_MAX = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] O_MIN = -O_MAX - SW'(1);

  typedef enum logic [1:0] {IDLE, CALC, MIX} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               ch_q, ch_d;
  logic [CHANNELS*CRSH_W-1:0]  snap_q, snap_d;
  logic [CHANNELS*CRSH_W-1:0]  last_q, last_d;
  logic signed [23:0]          y1_q [CHANNELS];
  logic signed [23:0]          y1_d [CHANNELS];
  logic signed [23:0]          y2_q [CHANNELS];
  logic signed [23:0]          y2_d [CHANNELS];
  logic [CHANNELS-1:0]         act_q, act_d;
  logic                        upd_q, upd_d;
  logic signed [OUT_W-1:0]     sum_q, sum_d;
  logic signed [OUT_W-1:0]     out_q, out_d;
  logic [CHANNELS-1:0]         active_q, active_d;
  logic                        valid_q, valid_d;

  logic [CRSH_W-1:0]           cur_snap, cur_last;
  logic signed [PW-1:0]        y1_ext, y2_ext, snap_ext, diff, ynew_ext;
  logic signed [23:0]          y_new, y_kick;
  logic                        kick, small_new, small_old;
  logic signed [SW-1:0]        mix_sum;

  function automatic logic signed [23:0] sat24(input logic signed [PW-1:0] v);
    if (v > Y_MAX) return 24'sh7FFFFF;
    if (v < Y_MIN) return 24'sh800000;
    return v[23:0];
  endfunction

  // Shared datapath: operands are muxed from whichever channel CALC is visiting.
  always_comb begin
    cur_snap  = snap_q[int'(ch_q)*CRSH_W +: CRSH_W];
    cur_last  = last_q[int'(ch_q)*CRSH_W +: CRSH_W];
    y1_ext    = PW'(y1_q[ch_q]);
    y2_ext    = PW'(y2_q[ch_q]);
    snap_ext  = PW'(cur_snap);
    kick      = (cur_snap != '0) && (cur_snap != cur_last);
    diff      = (A1_S * y1_ext) - (A2_S * y2_ext);
    y_new     = sat24(diff >>> 14);
    y_kick    = sat24(snap_ext * K_S);
    ynew_ext  = PW'(y_new);
    small_new = (ynew_ext > -FL_S) && (ynew_ext < FL_S);
    small_old = (y1_ext > -FL_S) && (y1_ext < FL_S);
    mix_sum   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mix_sum = mix_sum + SW'(y1_q[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    snap_d   = snap_q;
    last_d   = last_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    act_d    = act_q;
    upd_d    = 1'b0;
    sum_d    = sum_q;
    out_d    = out_q;
    active_d = active_q;
    valid_d  = 1'b0;
    if (upd_q) begin
      out_d    = sum_q;
      active_d = act_q;
      valid_d  = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (clk_en_48KHz) begin
          snap_d  = crsh;
          ch_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        last_d[int'(ch_q)*CRSH_W +: CRSH_W] = cur_snap;
        if (kick) begin
          y1_d[ch_q]  = y_kick;
          y2_d[ch_q]  = '0;
          act_d[ch_q] = 1'b1;
        end else if (act_q[ch_q] && !(small_new && small_old)) begin
          y2_d[ch_q] = y1_q[ch_q];
          y1_d[ch_q] = y_new;
        end else begin
          y1_d[ch_q]  = '0;
          y2_d[ch_q]  = '0;
          act_d[ch_q] = 1'b0;
        end
        if (ch_q == CW'(CHANNELS - 1)) state_d = MIX;
        else                           ch_d    = ch_q + 1'b1;
      end
      MIX: begin
        if (mix_sum > O_MAX)      sum_d = O_MAX[OUT_W-1:0];
        else if (mix_sum < O_MIN) sum_d = O_MIN[OUT_W-1:0];
        else                      sum_d = mix_sum[OUT_W-1:0];
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      snap_q   <= '0;
      last_q   <= '0;
      y1_q     <= '{default: '0};
      y2_q     <= '{default: '0};
      act_q    <= '0;
      upd_q    <= 1'b0;
      sum_q    <= '0;
      out_q    <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      snap_q   <= snap_d;
      last_q   <= last_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      act_q    <= act_d;
      upd_q    <= upd_d;
      sum_q    <= sum_d;
      out_q    <= out_d;
      active_q <= active_d;
      valid_q  <= valid_d;
    end
  end

  assign out          = out_q;
  assign active       = active_q;
  assign sample_valid = valid_q;

endmodule

// File: doc/bang_bank.md
BANG_BANK -- requirements
Module: bang_bank

Interface
REQ-001 Parameters (name, default, meaning):
- CHANNELS, 2, independent crash voices
- CRSH_W, 4, crash-level width per channel
- OUT_W, 16, signed mixed-output width
- A1_Q14, 32745, 2*r*cos(2*pi/432) in Q2.14
- A2_Q14, 16364, r^2 in Q2.14
- KICK_GAIN, 16, impulse amplitude per crash LSB
- FLOOR, 4, silence threshold on state magnitude
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- clk_en_48KHz, in, 1, one-cycle sample strobe
- crsh, in, CHANNELS*CRSH_W, unsigned crash level; channel c occupies bits [c*CRSH_W +: CRSH_W]
- out, out, OUT_W, signed mixed sample
- active, out, CHANNELS, per-channel ringing flag
- sample_valid, out, 1, one-cycle pulse when out/active update

Function
REQ-003 Each channel SHALL be a damped two-pole resonator with 24-bit signed state y1 (last) and y2 (previous).
REQ-004 The controller SHALL use states IDLE, CALC, MIX. IDLE->CALC on clk_en_48KHz. CALC runs one channel per cycle, c=0..CHANNELS-1, then goes to MIX. MIX->IDLE after one cycle.
REQ-005 crsh SHALL be snapshotted in the IDLE->CALC cycle; later crsh changes SHALL NOT affect that sample.
REQ-006 clk_en_48KHz asserted outside IDLE SHALL be ignored.
REQ-007 Kick: if the snapshot for channel c is nonzero and differs from that channel's last snapshot, then:
- y_new = snapshot*KICK_GAIN
- y2 <= 0
- active[c] <= 1
- the kick overrides any ringing in progress.
REQ-008 Otherwise, while active[c]=1:
- y_new = (A1_Q14*y1 - A2_Q14*y2) >>> 14, arithmetic shift, floor rounding
- product and difference at 40 bits or more
- result saturated to the 24-bit signed range
- then y2 <= y1, y1 <= y_new.
REQ-009 Floor: on a non-kick sample, if |y_new| < FLOOR and |y1| < FLOOR (pre-update y1), the channel SHALL clear y1 and y2 to 0 and clear active[c]. A channel with active=0 SHALL hold state 0.
REQ-010 The last snapshot per channel SHALL update every sample, including zero values, so a repeated equal level never re-kicks.
REQ-011 In MIX, the sum of all channels' y1 SHALL be formed at 24+clog2(CHANNELS)+1 bits and saturated to OUT_W signed (+32767/-32768 at the default width).
REQ-012 out, active and sample_valid SHALL update exactly CHANNELS+2 clk cycles after the accepted clk_en_48KHz edge. out and active SHALL hold between updates. sample_valid SHALL be high for exactly that one cycle.
REQ-013 A single shared multiplier pair, time-multiplexed across channels, is sufficient and intended. The design SHALL require CHANNELS+3 or more clk cycles between strobes.

Reset
REQ-014 On reset_n low, asynchronously:
- out=0, active=0, sample_valid=0
- all y1, y2 and last snapshots = 0
- state=IDLE
REQ-015 Reset asserted mid-sequence SHALL abort the sequence. After release, no output update SHALL occur until a new strobe.

Verification
REQ-016 Reset, no strobe:
- out=0, active=0, sample_valid=0
- one strobe with crsh=0 -> sample_valid pulse at cycle CHANNELS+2, out=0.
REQ-017 Defaults, ch0 crsh=15 held:
- first three updates out = 240, 479, 717
- active=01
- repeated crsh=15 never re-kicks.
REQ-018 Both channels crsh=15 on the same strobe -> out = 480, 958, 1434, active=11. Then ch1 set to 1 mid-ring -> ch1 restarts at y=16 the next sample.
REQ-019 FLOOR=300, ch0 crsh=1:
- out=16 with active=01
- next sample out=0, active=00
- remains 0 thereafter.
REQ-020 KICK_GAIN=2048, crsh=15:
- internal state reaches >= 1,900,000 without 24-bit overflow
- out clamps at +32767 and -32768
- no wrap.
REQ-021 Other sequencing checks:
- strobe during CALC -> ignored, one update only
- reset_n low during CALC -> outputs 0 immediately, no sample_valid until the next strobe.
